// File: rtl/tanh_preact_mac.sv
`default_nettype none
// ============================================================================
// Module      : tanh_preact_mac
// Description : Q8.8 multiply-accumulate with bias, arithmetic shift and
//               saturation, producing the pre-activation x for a tanh PWL.
//               Optional macro TANH_PREACT_ROUND_EN enables round-half-up.
// Revision    : 1.0 - initial release
// ============================================================================
module tanh_preact_mac #(
    parameter int N_TERMS = 8,
    parameter int ACC_W   = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_w,
    input  logic        in_last,
    input  logic [15:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_x,
    output logic        out_sat
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_OUT   = 2'd2;

    localparam int c_RW = ACC_W + 1;
    localparam logic [7:0] c_N_TERMS = 8'(N_TERMS);
    localparam logic signed [c_RW-1:0] c_SAT_MAX = c_RW'(32767);
    localparam logic signed [c_RW-1:0] c_SAT_MIN = c_RW'(-32768);
`ifdef TANH_PREACT_ROUND_EN
    localparam logic signed [c_RW-1:0] c_RND = c_RW'(128);
`else
    localparam logic signed [c_RW-1:0] c_RND = c_RW'(0);
`endif

    logic [1:0]              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [7:0]              r_cnt;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic [15:0]             r_out_x;
    logic                    r_out_sat;

    logic                    w_in_fire;
    logic                    w_out_fire;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [7:0]              w_cnt_next;
    logic                    w_close;
    logic signed [c_RW-1:0]  w_acc_wide;
    logic signed [c_RW-1:0]  w_shift;
    logic signed [c_RW-1:0]  w_sum;
    logic                    w_sat_hi;
    logic                    w_sat_lo;
    logic [15:0]             w_x_clip;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    assign w_prod     = $signed(in_a) * $signed(in_w);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_acc_next = r_acc + w_prod_ext;
    assign w_cnt_next = r_cnt + 8'd1;
    assign w_close    = w_in_fire & (in_last | (w_cnt_next == c_N_TERMS));

    // One extra bit of headroom so rounding and bias can never overflow.
    assign w_acc_wide = c_RW'(w_acc_next) + c_RND;
    assign w_shift    = w_acc_wide >>> 8;
    assign w_sum      = w_shift + c_RW'($signed(bias));

    assign w_sat_hi   = (w_sum > c_SAT_MAX);
    assign w_sat_lo   = (w_sum < c_SAT_MIN);
    assign w_x_clip   = w_sat_hi ? 16'h7FFF :
                        w_sat_lo ? 16'h8000 : w_sum[15:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_x     <= 16'h0000;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE, c_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        if (w_close) begin
                            r_out_x     <= w_x_clip;
                            r_out_sat   <= w_sat_hi | w_sat_lo;
                            r_out_valid <= 1'b1;
                            r_in_ready  <= 1'b0;
                            r_state     <= c_OUT;
                        end else begin
                            r_acc   <= w_acc_next;
                            r_cnt   <= w_cnt_next;
                            r_state <= c_ACCUM;
                        end
                    end
                end
                c_OUT: begin
                    // Result held until the consumer takes it.
                    if (w_out_fire) begin
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_sat   = r_out_sat;

endmodule
`default_nettype wire

// File: tb/tb_tanh_preact_mac.sv
`default_nettype none
// Self-checking bench for tanh_preact_mac: arithmetic reference model plus
// directed vectors with literal expected results.
module tb_tanh_preact_mac;

    localparam int N  = 8;
    localparam int AW = 40;
`ifdef TANH_PREACT_ROUND_EN
    localparam longint RND = 128;
`else
    localparam longint RND = 0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_w;
    logic        in_last;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x;
    logic        out_sat;

    int n_checks;
    int n_errors;

    longint      m_acc;
    int          m_cnt;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_x;
    logic        m_sat;

    tanh_preact_mac #(.N_TERMS(N), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_w      (in_w),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x     (out_x),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic of the dot product.
    initial begin
        longint s;
        longint r;
        int     n;
        m_acc = 0; m_cnt = 0; m_valid = 0; m_ready = 0; m_x = 0; m_sat = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_acc = 0; m_cnt = 0; m_valid = 0; m_ready = 0; m_x = 0; m_sat = 0;
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 0; m_acc = 0; m_cnt = 0; m_ready = 1;
                end
            end else begin
                if (in_valid && m_ready) begin
                    s = m_acc + longint'($signed(in_a)) * longint'($signed(in_w));
                    s = s <<< (64 - AW);
                    s = s >>> (64 - AW);
                    n = m_cnt + 1;
                    if (in_last || n == N) begin
                        r = ((s + RND) >>> 8) + longint'($signed(bias));
                        if (r > 32767) begin
                            m_x = 16'h7FFF; m_sat = 1;
                        end else if (r < -32768) begin
                            m_x = 16'h8000; m_sat = 1;
                        end else begin
                            m_x = r[15:0]; m_sat = 0;
                        end
                        m_valid = 1;
                    end else begin
                        m_acc = s;
                        m_cnt = n;
                    end
                end
                m_ready = !m_valid;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_in_ready", {31'd0, in_ready}, {31'd0, m_ready});
            chk("cyc_out_valid", {31'd0, out_valid}, {31'd0, m_valid});
            if (m_valid || rst) begin
                chk("cyc_out_x", {16'd0, out_x}, {16'd0, m_x});
                chk("cyc_out_sat", {31'd0, out_sat}, {31'd0, m_sat});
            end
        end
    end

    task automatic send_term(input logic [15:0] a, input logic [15:0] w,
                             input logic l, input logic [15:0] b);
        bit ok;
        ok = 0;
        in_valid = 1; in_a = a; in_w = w; in_last = l; bias = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (m_ready) ok = 1;
            @(posedge clk); #1;
        end
        in_valid = 0; in_last = 0; in_a = 16'hDEAD; in_w = 16'hBEEF; bias = 16'h5A5A;
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL send_timeout: term never accepted, got none expected handshake");
        end
    endtask

    task automatic wait_out(input logic [15:0] ex, input logic es, input string name);
        bit got;
        got = 0;
        out_ready = 1;
        for (int i = 0; i < 30 && !got; i++) begin
            if (out_valid) begin
                chk({name, "_x"}, {16'd0, out_x}, {16'd0, ex});
                chk({name, "_sat"}, {31'd0, out_sat}, {31'd0, es});
                got = 1;
            end
            @(posedge clk); #1;
        end
        out_ready = 0;
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL %s_timeout: out_valid 0 expected 1", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; in_valid = 0; in_a = 0; in_w = 0; in_last = 0; bias = 0; out_ready = 0;
        n_checks = 0; n_errors = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_x", {16'd0, out_x}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst = 0;
        @(posedge clk); #1;

        // 1.0 * 1.0, one-cycle latency
        send_term(16'h0100, 16'h0100, 1'b1, 16'h0000);
        chk("lat1_valid", {31'd0, out_valid}, 32'd1);
        wait_out(16'h0100, 1'b0, "one_term");

        // -1.0 * 2.0 + 0.5 = -1.5
        send_term(16'hFF00, 16'h0200, 1'b1, 16'h0080);
        wait_out(16'hFE80, 1'b0, "neg_bias");

        // Bias only sampled on the closing term: 3.0 - 0.5 + 0.0625 + 0.0625
        send_term(16'h0200, 16'h0180, 1'b0, 16'h7777);
        send_term(16'h0100, 16'hFF80, 1'b0, 16'h7777);
        send_term(16'h0040, 16'h0040, 1'b1, 16'h0010);
        wait_out(16'h02A0, 1'b0, "three_term");

        // Forced close after N terms, positive and negative saturation
        for (int i = 0; i < N; i++) send_term(16'h7FFF, 16'h7FFF, 1'b0, 16'h0000);
        wait_out(16'h7FFF, 1'b1, "sat_pos");
        for (int i = 0; i < N; i++) send_term(16'h8001, 16'h7FFF, 1'b0, 16'h0000);
        wait_out(16'h8000, 1'b1, "sat_neg");

        // Saturation boundaries: 32767+1 clips, exactly -32768 does not
        send_term(16'h7FFF, 16'h0100, 1'b1, 16'h0001);
        wait_out(16'h7FFF, 1'b1, "edge_hi");
        send_term(16'h8000, 16'h0100, 1'b1, 16'h0000);
        wait_out(16'h8000, 1'b0, "edge_lo");

        // Rounding option
        send_term(16'h0001, 16'h0080, 1'b1, 16'h0000);
`ifdef TANH_PREACT_ROUND_EN
        wait_out(16'h0001, 1'b0, "round");
`else
        wait_out(16'h0000, 1'b0, "trunc");
`endif

        // Backpressure: result held, input pulses ignored
        send_term(16'h0300, 16'h0100, 1'b1, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_a = 16'h7FFF; in_w = 16'h7FFF; in_last = 1'(i); bias = 16'h1234;
            chk("bp_out_x", {16'd0, out_x}, 32'h0300);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 0; in_last = 0;
        wait_out(16'h0300, 1'b0, "bp_out");
        send_term(16'h0100, 16'h0100, 1'b1, 16'h0000);
        wait_out(16'h0100, 1'b0, "post_bp");

        // Reset mid-accumulation discards the partial sum
        for (int i = 0; i < 3; i++) send_term(16'h0100, 16'h0100, 1'b0, 16'h0000);
        rst = 1;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        send_term(16'h0100, 16'h0100, 1'b1, 16'h0000);
        wait_out(16'h0100, 1'b0, "post_rst");

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
